rtc_calendar: RTL
=================

Name: rtc_calendar

Overview:
Parametrised single-clock real-time clock/calendar. It replaces the ripple-clocked second/minute/hour/day/month/year counter chain with one synchronous design.
- A prescaler generates a 1 Hz clock-enable. All calendar fields update on the same clk edge.
- Full Gregorian leap-year rule.
- Validated set (load) handshake for writing the time.
- Optional compile-time alarm.

Parameters:
CLK_HZ, 50000000, input clock frequency; the prescaler counts 0..CLK_HZ-1 (legal: CLK_HZ >= 2).
YEAR_W, 16, width of the year field.
RESET_YEAR, 2000, year value loaded on reset (must fit in YEAR_W bits).

Ports:
clk  in  1  system clock; the only clock in the block.
rst_n  in  1  asynchronous, active-low reset.
set_valid  in  1  set request.
set_ready  out  1  set request can be accepted this cycle.
set_second  in  6  set value, 0..59.
set_minute  in  6  set value, 0..59.
set_hour  in  5  set value, 0..23.
set_day  in  5  set value, 1..days_in_month(set_month, set_year).
set_month  in  4  set value, 1..12.
set_year  in  YEAR_W  set value, any.
set_done  out  1  one-cycle pulse: set applied.
set_err  out  1  one-cycle pulse: set rejected.
tick_1hz  out  1  one-cycle pulse per second.
second  out  6  current second.
minute  out  6  current minute.
hour  out  5  current hour.
day  out  5  current day of month.
month  out  4  current month.
year  out  YEAR_W  current year.
alarm_en  in  1  alarm enable (used only with RTC_ALARM_EN).
alarm_hour  in  5  alarm hour (used only with RTC_ALARM_EN).
alarm_minute  in  6  alarm minute (used only with RTC_ALARM_EN).
alarm_hit  out  1  one-cycle alarm pulse.

Behaviour:
- Reset, asserted asynchronously:
  - second=0, minute=0, hour=0, day=1, month=1, year=RESET_YEAR.
  - Prescaler=0, tick_1hz=0, set_done=0, set_err=0, alarm_hit=0.
  - FSM=IDLE, so set_ready=1.
- Prescaler:
  - Increments every cycle and wraps at CLK_HZ-1.
  - tick_1hz is registered high for exactly the one cycle after the count reaches CLK_HZ-1, i.e. once every CLK_HZ cycles.
  - The first tick occurs CLK_HZ cycles after reset release.
- Advance, on a tick (all fields use registered next-state values, single edge):
  - second+1. At 59: second=0, minute+1.
  - minute at 59: minute=0, hour+1.
  - hour at 23: hour=0, day+1.
  - day at dim: day=1, month+1.
  - month at 12: month=1, year+1.
  - year wraps from 2^YEAR_W-1 to 0.
- dim (days in month):
  - 31 for months 1, 3, 5, 7, 8, 10, 12.
  - 30 for months 4, 6, 9, 11.
  - February: 29 if leap, else 28.
  - Leap year: (y%4==0) and ((y%100!=0) or (y%400==0)). Compute without a general divider, e.g. low-bit test plus a constant-modulus compare.
- Set FSM, IDLE -> CHECK -> IDLE:
  - IDLE: set_ready=1. On set_valid&&set_ready, capture all set_* into holding registers and go to CHECK.
  - CHECK: set_ready=0. Range-check the held values (dim uses the held month/year).
    - Valid: load all fields, clear the prescaler to 0, pulse set_done. The next tick comes exactly CLK_HZ cycles later.
    - Invalid: leave fields unchanged, pulse set_err.
    - Either way, return to IDLE.
- Set/tick interactions:
  - A tick in the CHECK cycle advances the fields normally.
  - If the set is valid, the applied set overrides that tick's advance; tick_1hz still pulses.
  - set_valid held high re-requests on the next IDLE cycle; maximum throughput is one set per 2 cycles.
- Reset mid-CHECK discards the held set. No set_done or set_err pulse is produced.

Optional Feature:
RTC_ALARM_EN
- Defined: alarm_hit pulses for one cycle, coincident with tick_1hz, when all of these hold:
  - the tick moves the time to hour==alarm_hour, minute==alarm_minute, second==0;
  - alarm_en=1.
- Defined: a set that loads a matching hh:mm:00 does not fire the alarm.
- Not defined: alarm_hit is tied to 0, alarm_* inputs are unused, and no alarm logic is synthesised. Ports are present in both builds.

Test Plan:
All scenarios use CLK_HZ=4.
1. Reset release, then 4 cycles -> tick_1hz pulse, second=1. After 60 ticks -> minute=1, second=0.
2. Set 23:59:59 31/12/2023, then 1 tick -> 00:00:00, day=1, month=1, year=2024, all on the same edge.
3. Set 28/02/2023 23:59:59, then 1 tick -> day=1, month=3. Repeat with years:
   - 2024 -> day=29, month=2.
   - 2100 -> day=1, month=3.
   - 2000 -> day=29, month=2.
4. Set day=31, month=4 -> set_err pulse, time unchanged. Set 29/02/2023 -> set_err. A valid set issued 2 cycles before a tick -> set_done, next tick 4 cycles after apply.
5. Assert rst_n low while in CHECK and mid-count -> outputs immediately 00:00:00 01/01/RESET_YEAR, no set_done or set_err, set_ready=1.
6. RTC_ALARM_EN with alarm 07:30, set 07:29:59, 1 tick -> alarm_hit for 1 cycle. With alarm_en=0 -> no pulse. Set 07:30:00 directly -> no pulse.

Source files
------------

// File: rtl/rtc_calendar.sv
// Single-clock RTC/calendar: 1 Hz prescaler, Gregorian calendar and a validated set handshake.
// Optional alarm compare is compiled in when RTC_ALARM_EN is defined.
module rtc_calendar #(
  parameter int CLK_HZ     = 50000000,
  parameter int YEAR_W     = 16,
  parameter int RESET_YEAR = 2000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              set_valid,
  output logic              set_ready,
  input  logic [5:0]        set_second,
  input  logic [5:0]        set_minute,
  input  logic [4:0]        set_hour,
  input  logic [4:0]        set_day,
  input  logic [3:0]        set_month,
  input  logic [YEAR_W-1:0] set_year,
  output logic              set_done,
  output logic              set_err,
  output logic              tick_1hz,
  output logic [5:0]        second,
  output logic [5:0]        minute,
  output logic [4:0]        hour,
  output logic [4:0]        day,
  output logic [3:0]        month,
  output logic [YEAR_W-1:0] year,
  input  logic              alarm_en,
  input  logic [4:0]        alarm_hour,
  input  logic [5:0]        alarm_minute,
  output logic              alarm_hit
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);

  typedef enum logic {ST_IDLE, ST_CHECK} state_t;

  // Divisible by 400 == divisible by 16 and by 25; only a constant modulus is needed.
  function automatic logic f_leap(input logic [YEAR_W-1:0] y);
    return (y[1:0] == 2'b00) && (((y % YEAR_W'(25)) != '0) || (y[3:0] == 4'b0000));
  endfunction

  function automatic logic [4:0] f_dim(input logic [3:0] m, input logic [YEAR_W-1:0] y);
    case (m)
      4'd4, 4'd6, 4'd9, 4'd11: return 5'd30;
      4'd2:                    return f_leap(y) ? 5'd29 : 5'd28;
      default:                 return 5'd31;
    endcase
  endfunction

  logic [PW-1:0]     r_presc;
  logic              r_tick;
  logic [5:0]        r_sec, r_min;
  logic [4:0]        r_hour, r_day;
  logic [3:0]        r_mon;
  logic [YEAR_W-1:0] r_year;

  state_t            r_state;
  logic              r_ready, r_done, r_err;
  logic [5:0]        r_h_sec, r_h_min;
  logic [4:0]        r_h_hour, r_h_day;
  logic [3:0]        r_h_mon;
  logic [YEAR_W-1:0] r_h_year;

  logic              w_tick, w_set_ok, w_apply;
  logic [4:0]        w_dim_cur;
  logic [5:0]        w_nsec, w_nmin;
  logic [4:0]        w_nhour, w_nday;
  logic [3:0]        w_nmon;
  logic [YEAR_W-1:0] w_nyear;

  assign w_tick    = (r_presc == PRESC_MAX);
  assign w_dim_cur = f_dim(r_mon, r_year);
  assign w_set_ok  = (r_h_sec <= 6'd59) && (r_h_min <= 6'd59) && (r_h_hour <= 5'd23) &&
                     (r_h_mon != 4'd0) && (r_h_mon <= 4'd12) &&
                     (r_h_day != 5'd0) && (r_h_day <= f_dim(r_h_mon, r_h_year));
  assign w_apply   = (r_state == ST_CHECK) && w_set_ok;

  always_comb begin
    w_nsec  = r_sec;
    w_nmin  = r_min;
    w_nhour = r_hour;
    w_nday  = r_day;
    w_nmon  = r_mon;
    w_nyear = r_year;
    if (w_tick) begin
      if (r_sec != 6'd59) w_nsec = r_sec + 6'd1;
      else begin
        w_nsec = '0;
        if (r_min != 6'd59) w_nmin = r_min + 6'd1;
        else begin
          w_nmin = '0;
          if (r_hour != 5'd23) w_nhour = r_hour + 5'd1;
          else begin
            w_nhour = '0;
            if (r_day != w_dim_cur) w_nday = r_day + 5'd1;
            else begin
              w_nday = 5'd1;
              if (r_mon != 4'd12) w_nmon = r_mon + 4'd1;
              else begin
                w_nmon  = 4'd1;
                w_nyear = r_year + YEAR_W'(1);
              end
            end
          end
        end
      end
    end
  end

  // A valid set overrides the tick's advance and restarts the second.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
      r_tick  <= 1'b0;
      r_sec   <= '0;
      r_min   <= '0;
      r_hour  <= '0;
      r_day   <= 5'd1;
      r_mon   <= 4'd1;
      r_year  <= YEAR_W'(RESET_YEAR);
    end else begin
      r_tick  <= w_tick;
      r_presc <= (w_apply || w_tick) ? '0 : r_presc + PW'(1);
      if (w_apply) begin
        r_sec  <= r_h_sec;
        r_min  <= r_h_min;
        r_hour <= r_h_hour;
        r_day  <= r_h_day;
        r_mon  <= r_h_mon;
        r_year <= r_h_year;
      end else begin
        r_sec  <= w_nsec;
        r_min  <= w_nmin;
        r_hour <= w_nhour;
        r_day  <= w_nday;
        r_mon  <= w_nmon;
        r_year <= w_nyear;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_ready  <= 1'b1;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_h_sec  <= '0;
      r_h_min  <= '0;
      r_h_hour <= '0;
      r_h_day  <= '0;
      r_h_mon  <= '0;
      r_h_year <= '0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (set_valid && r_ready) begin
            r_h_sec  <= set_second;
            r_h_min  <= set_minute;
            r_h_hour <= set_hour;
            r_h_day  <= set_day;
            r_h_mon  <= set_month;
            r_h_year <= set_year;
            r_state  <= ST_CHECK;
            r_ready  <= 1'b0;
          end
        end
        ST_CHECK: begin
          r_done  <= w_set_ok;
          r_err   <= !w_set_ok;
          r_state <= ST_IDLE;
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

`ifdef RTC_ALARM_EN
  logic r_alarm;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_alarm <= 1'b0;
    else        r_alarm <= w_tick && !w_apply && alarm_en && (w_nsec == '0) &&
                           (w_nhour == alarm_hour) && (w_nmin == alarm_minute);
  end

  assign alarm_hit = r_alarm;
`else
  logic w_alarm_unused;
  assign w_alarm_unused = ^{alarm_en, alarm_hour, alarm_minute};
  assign alarm_hit      = 1'b0;
`endif

  assign set_ready = r_ready;
  assign set_done  = r_done;
  assign set_err   = r_err;
  assign tick_1hz  = r_tick;
  assign second    = r_sec;
  assign minute    = r_min;
  assign hour      = r_hour;
  assign day       = r_day;
  assign month     = r_mon;
  assign year      = r_year;

endmodule
